// File: rtl/onehot_hit_monitor.sv
// Health monitor for a one-hot decode bus: checks legality, re-encodes legal words,
// and keeps saturating per-line hit counters and an illegal-word counter with an optional halt.
module onehot_hit_monitor #(
    parameter int N           = 8,
    parameter int CW          = 8,
    parameter bit HALT_ON_ERR = 1'b0,
    localparam int IW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  y_in,
    input  logic          y_valid,
    input  logic          clear,
    input  logic [IW-1:0] rd_sel,
    output logic [CW-1:0] rd_count,
    output logic [IW-1:0] last_idx,
    output logic          idx_valid,
    output logic          err_flag,
    output logic [CW-1:0] err_count,
    output logic          halted
);

    // Handshake: y_in is consumed on any rising edge where y_valid is high,
    // the FSM is in RUN and clear is low; there is no back-pressure.

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic          legal;
    logic [IW-1:0] enc;
    logic [CW-1:0] cnt [N];

    // Exactly one bit set; X/Z makes the condition unknown, which falls to the illegal branch.
    always_comb begin
        legal = (y_in != '0) && ((y_in & (y_in - ONE_N)) == '0);
    end

    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (y_in[i]) begin
                enc = enc | IW'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (!clear && y_valid && HALT_ON_ERR) begin
                    if (legal) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (clear) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            rd_count  <= '0;
            last_idx  <= '0;
            idx_valid <= 1'b0;
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            // Readback always reflects the counter value before this edge's update.
            rd_count  <= cnt[rd_sel];
            idx_valid <= 1'b0;
            if (clear) begin
                for (int i = 0; i < N; i++) begin
                    cnt[i] <= '0;
                end
                last_idx  <= '0;
                err_flag  <= 1'b0;
                err_count <= '0;
            end else if (state == RUN && y_valid) begin
                if (legal) begin
                    if (cnt[enc] != CNT_MAX) begin
                        cnt[enc] <= cnt[enc] + CW'(1);
                    end
                    last_idx  <= enc;
                    idx_valid <= 1'b1;
                end else begin
                    if (err_count != CNT_MAX) begin
                        err_count <= err_count + CW'(1);
                    end
                    err_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_hit_monitor.sv
// Bench for onehot_hit_monitor: two instances (8-bit counters free-running, 4-bit counters
// with halt-on-error) share one stimulus stream and are compared against a behavioural model.
module tb_onehot_hit_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] y_in = '0;
    logic       y_valid = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] rd_sel = '0;

    logic [7:0] a_rd_count, a_err_count;
    logic [2:0] a_last_idx;
    logic       a_idx_valid, a_err_flag, a_halted;
    logic [3:0] b_rd_count, b_err_count;
    logic [2:0] b_last_idx;
    logic       b_idx_valid, b_err_flag, b_halted;

    int checks   = 0;
    int failures = 0;

    // Reference state, index 0 = instance a, index 1 = instance b.
    int m_cnt [2][8];
    int m_err [2];
    int m_flag[2];
    int m_last[2];
    int m_idxv[2];
    int m_halt[2];
    int m_rdc [2];
    int m_max [2] = '{255, 15};
    int m_hen [2] = '{0, 1};

    always #5 clk = ~clk;

    onehot_hit_monitor #(.N(8), .CW(8), .HALT_ON_ERR(1'b0)) u_a (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .clear(clear), .rd_sel(rd_sel),
        .rd_count(a_rd_count), .last_idx(a_last_idx), .idx_valid(a_idx_valid),
        .err_flag(a_err_flag), .err_count(a_err_count), .halted(a_halted)
    );

    onehot_hit_monitor #(.N(8), .CW(4), .HALT_ON_ERR(1'b1)) u_b (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .clear(clear), .rd_sel(rd_sel),
        .rd_count(b_rd_count), .last_idx(b_last_idx), .idx_valid(b_idx_valid),
        .err_flag(b_err_flag), .err_count(b_err_count), .halted(b_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit legal;
        int k;
        legal = !$isunknown(y_in) && ($countones(y_in) == 1);
        k = 0;
        for (int b = 0; b < 8; b++) begin
            if (y_in[b] === 1'b1) k = b;
        end
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) m_cnt[u][i] = 0;
                m_err[u] = 0; m_flag[u] = 0; m_last[u] = 0;
                m_idxv[u] = 0; m_halt[u] = 0; m_rdc[u] = 0;
            end else begin
                int rdc_new;
                rdc_new = m_cnt[u][rd_sel];
                m_idxv[u] = 0;
                if (clear) begin
                    for (int i = 0; i < 8; i++) m_cnt[u][i] = 0;
                    m_err[u] = 0; m_flag[u] = 0; m_last[u] = 0; m_halt[u] = 0;
                end else if (m_halt[u] == 0 && y_valid) begin
                    if (legal) begin
                        if (m_cnt[u][k] < m_max[u]) m_cnt[u][k] = m_cnt[u][k] + 1;
                        m_last[u] = k;
                        m_idxv[u] = 1;
                    end else begin
                        if (m_err[u] < m_max[u]) m_err[u] = m_err[u] + 1;
                        m_flag[u] = 1;
                        if (m_hen[u] != 0) m_halt[u] = 1;
                    end
                end
                m_rdc[u] = rdc_new;
            end
        end
    endtask

    task automatic check_all();
        check("a_rd_count",  a_rd_count,  m_rdc[0]);
        check("a_last_idx",  a_last_idx,  m_last[0]);
        check("a_idx_valid", a_idx_valid, m_idxv[0]);
        check("a_err_flag",  a_err_flag,  m_flag[0]);
        check("a_err_count", a_err_count, m_err[0]);
        check("a_halted",    a_halted,    m_halt[0]);
        check("b_rd_count",  b_rd_count,  m_rdc[1]);
        check("b_last_idx",  b_last_idx,  m_last[1]);
        check("b_idx_valid", b_idx_valid, m_idxv[1]);
        check("b_err_flag",  b_err_flag,  m_flag[1]);
        check("b_err_count", b_err_count, m_err[1]);
        check("b_halted",    b_halted,    m_halt[1]);
    endtask

    task automatic step(input logic s_rst, input logic s_clr, input logic s_vld,
                        input logic [7:0] s_y, input logic [2:0] s_sel);
        rst = s_rst; clear = s_clr; y_valid = s_vld; y_in = s_y; rd_sel = s_sel;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic sweep_readback();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 3'(i));
        step(1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    endtask

    initial begin
        logic [7:0] y_x;
        logic [7:0] ry;
        y_x = 'x;

        // Reset, then every readback index must be zero.
        step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        sweep_readback();

        // Walking one across all lines.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'(1 << i), 3'(i));
        sweep_readback();

        // Zero, multi-hot and unknown words are all illegal.
        step(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
        step(1'b0, 1'b0, 1'b1, 8'h03, 3'd1);
        step(1'b0, 1'b0, 1'b1, y_x,   3'd2);
        sweep_readback();

        // Saturation: 4-bit instance tops out at 15, 8-bit at 255.
        step(1'b0, 1'b1, 1'b0, 8'h00, 3'd3);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'h08, 3'd3);
        step(1'b0, 1'b0, 1'b0, 8'h00, 3'd3);
        for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 1'b1, 8'h80, 3'd7);
        step(1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
        step(1'b0, 1'b0, 1'b0, 8'h00, 3'd7);

        // Halt on error, frozen counters, then clear back to RUN.
        step(1'b0, 1'b1, 1'b0, 8'h00, 3'd4);
        step(1'b0, 1'b0, 1'b1, 8'h10, 3'd4);
        step(1'b0, 1'b0, 1'b1, 8'h11, 3'd4);
        step(1'b0, 1'b0, 1'b1, 8'h10, 3'd4);
        step(1'b0, 1'b0, 1'b0, 8'h00, 3'd4);
        step(1'b0, 1'b1, 1'b0, 8'h00, 3'd4);
        sweep_readback();

        // Clear beats a simultaneous sample; rst mid-stream.
        step(1'b0, 1'b0, 1'b1, 8'h00, 3'd5);
        step(1'b0, 1'b1, 1'b1, 8'h20, 3'd5);
        step(1'b0, 1'b0, 1'b0, 8'h00, 3'd5);
        step(1'b0, 1'b0, 1'b1, 8'h20, 3'd5);
        step(1'b0, 1'b0, 1'b1, 8'h40, 3'd5);
        step(1'b1, 1'b1, 1'b1, 8'h40, 3'd6);
        sweep_readback();

        // Randomized traffic: mostly one-hot, some arbitrary words, rare clear/rst.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7) ry = 8'(1 << $urandom_range(0, 7));
            else ry = 8'($urandom);
            step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 3) != 0), ry, 3'($urandom_range(0, 7)));
        end
        sweep_readback();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
